// File: rtl/memory_arbiter_mp.sv
// memory_arbiter_mp: N-port requester arbiter in front of two memory targets.
// One transaction at a time. The winner is chosen by round-robin or by fixed
// priority with a starvation guard. The target is selected by one address bit.
module memory_arbiter_mp #(
    parameter int NUM_PORTS      = 4,
    parameter int ADDR_WIDTH     = 27,
    parameter int DATA_WIDTH     = 16,
    parameter int MODE           = 0,
    parameter int STARVE_LIMIT   = 4,
    parameter int TARGET_SEL_BIT = 26
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [NUM_PORTS-1:0]                req,
    output logic [NUM_PORTS-1:0]                ack,
    input  logic [NUM_PORTS-1:0]                write,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]     address,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]     wdata,
    input  logic [NUM_PORTS*DATA_WIDTH/8-1:0]   wmask,
    output logic [DATA_WIDTH-1:0]               rdata,
    output logic [$clog2(NUM_PORTS)-1:0]        grant_id,
    output logic                                busy,
    output logic [1:0]                          tgt_req,
    input  logic [1:0]                          tgt_ack,
    output logic                                tgt_write,
    output logic [ADDR_WIDTH-1:0]               tgt_address,
    output logic [DATA_WIDTH-1:0]               tgt_wdata,
    output logic [DATA_WIDTH/8-1:0]             tgt_wmask,
    input  logic [2*DATA_WIDTH-1:0]             tgt_rdata
);

    localparam int GW = $clog2(NUM_PORTS);
    localparam int MW = DATA_WIDTH / 8;
    localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                state, state_nxt;
    logic [GW-1:0]         last_grant;
    logic [SW-1:0]         starve_cnt, starve_nxt;
    logic                  tgt_sel;
    logic                  grant_now;

    logic [GW:0]           rr_cand;
    logic                  rr_found;
    logic [GW-1:0]         rr_idx, pr_idx, win_idx;
    logic                  rr_force;
    logic                  multi_req;

    logic                  win_write;
    logic [ADDR_WIDTH-1:0] win_address;
    logic [DATA_WIDTH-1:0] win_wdata;
    logic [MW-1:0]         win_wmask;

    // Round-robin pick: first requester found walking upward from last_grant+1, wrapping.
    always_comb begin
        rr_idx   = '0;
        rr_found = 1'b0;
        rr_cand  = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            rr_cand = {1'b0, last_grant} + (GW+1)'(k + 1);
            if (rr_cand >= (GW+1)'(NUM_PORTS))
                rr_cand = rr_cand - (GW+1)'(NUM_PORTS);
            if (!rr_found && req[rr_cand[GW-1:0]]) begin
                rr_found = 1'b1;
                rr_idx   = rr_cand[GW-1:0];
            end
        end
    end

    // Fixed-priority pick: lowest requesting index.
    always_comb begin
        pr_idx = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            if (req[k])
                pr_idx = GW'(k);
        end
    end

    // The winner is always a requester, so "another port also requested" means
    // that more than one req bit is set.
    assign multi_req = |(req & (req - NUM_PORTS'(1)));
    assign rr_force  = (MODE == 0) ||
                       ((STARVE_LIMIT != 0) && (starve_cnt == SW'(STARVE_LIMIT)));
    assign win_idx   = rr_force ? rr_idx : pr_idx;

    // Starvation counter: counts contested priority wins and clears on a forced
    // round-robin grant or an uncontested grant.
    always_comb begin
        starve_nxt = starve_cnt;
        if ((MODE != 0) && (STARVE_LIMIT != 0) && grant_now) begin
            if (rr_force || !multi_req)
                starve_nxt = '0;
            else
                starve_nxt = starve_cnt + SW'(1);
        end
    end

    // Select the winner's payload slices.
    always_comb begin
        win_write   = 1'b0;
        win_address = '0;
        win_wdata   = '0;
        win_wmask   = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (win_idx == GW'(k)) begin
                win_write   = write[k];
                win_address = address[k*ADDR_WIDTH +: ADDR_WIDTH];
                win_wdata   = wdata[k*DATA_WIDTH +: DATA_WIDTH];
                win_wmask   = wmask[k*MW +: MW];
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic plus combinational target request, ack and read data.
    always_comb begin
        state_nxt = state;
        grant_now = 1'b0;
        tgt_req   = 2'b00;
        ack       = '0;
        rdata     = '0;
        case (state)
            IDLE: begin
                if (|req) begin
                    grant_now = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                tgt_req[tgt_sel] = 1'b1;
                if (tgt_ack[tgt_sel]) begin
                    ack[grant_id] = 1'b1;
                    rdata         = tgt_sel ? tgt_rdata[2*DATA_WIDTH-1:DATA_WIDTH]
                                            : tgt_rdata[DATA_WIDTH-1:0];
                    state_nxt     = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Grant bookkeeping and payload latch. The payload stays put after completion.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant_id    <= '0;
            last_grant  <= GW'(NUM_PORTS - 1);
            starve_cnt  <= '0;
            tgt_sel     <= 1'b0;
            tgt_write   <= 1'b0;
            tgt_address <= '0;
            tgt_wdata   <= '0;
            tgt_wmask   <= '0;
        end else begin
            starve_cnt <= starve_nxt;
            if (grant_now) begin
                grant_id    <= win_idx;
                last_grant  <= win_idx;
                tgt_sel     <= win_address[TARGET_SEL_BIT];
                tgt_write   <= win_write;
                tgt_address <= win_address;
                tgt_wdata   <= win_wdata;
                tgt_wmask   <= win_wmask;
            end
        end
    end

    assign busy = (state == BUSY);

endmodule

// File: tb/tb_memory_arbiter_mp.sv
// Bench for memory_arbiter_mp. Three instances (round-robin, priority with
// starvation limit 2, priority with the guard disabled) share the requester
// stimulus. Each instance has its own target responder and its own behavioural model.
module tb_memory_arbiter_mp;
    localparam int N  = 4;
    localparam int AW = 27;
    localparam int DW = 16;
    localparam int MW = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [N-1:0]    req = '0;
    logic [N-1:0]    write = '0;
    logic [N*AW-1:0] address = '0;
    logic [N*DW-1:0] wdata = '0;
    logic [N*MW-1:0] wmask = '0;
    logic [2*DW-1:0] tgt_rdata = {16'hBEEF, 16'h5A5A};

    logic [N-1:0]  ack_o   [3];
    logic [DW-1:0] rdata_o [3];
    logic [1:0]    gid_o   [3];
    logic          busy_o  [3];
    logic [1:0]    treq_o  [3];
    logic [1:0]    tack    [3];
    logic          twr_o   [3];
    logic [AW-1:0] taddr_o [3];
    logic [DW-1:0] twd_o   [3];
    logic [MW-1:0] twm_o   [3];

    memory_arbiter_mp #(.MODE(0)) u_rr (
        .clk(clk), .reset(reset), .req(req), .ack(ack_o[0]), .write(write),
        .address(address), .wdata(wdata), .wmask(wmask), .rdata(rdata_o[0]),
        .grant_id(gid_o[0]), .busy(busy_o[0]), .tgt_req(treq_o[0]), .tgt_ack(tack[0]),
        .tgt_write(twr_o[0]), .tgt_address(taddr_o[0]), .tgt_wdata(twd_o[0]),
        .tgt_wmask(twm_o[0]), .tgt_rdata(tgt_rdata));

    memory_arbiter_mp #(.MODE(1), .STARVE_LIMIT(2)) u_fp (
        .clk(clk), .reset(reset), .req(req), .ack(ack_o[1]), .write(write),
        .address(address), .wdata(wdata), .wmask(wmask), .rdata(rdata_o[1]),
        .grant_id(gid_o[1]), .busy(busy_o[1]), .tgt_req(treq_o[1]), .tgt_ack(tack[1]),
        .tgt_write(twr_o[1]), .tgt_address(taddr_o[1]), .tgt_wdata(twd_o[1]),
        .tgt_wmask(twm_o[1]), .tgt_rdata(tgt_rdata));

    memory_arbiter_mp #(.MODE(1), .STARVE_LIMIT(0)) u_fp0 (
        .clk(clk), .reset(reset), .req(req), .ack(ack_o[2]), .write(write),
        .address(address), .wdata(wdata), .wmask(wmask), .rdata(rdata_o[2]),
        .grant_id(gid_o[2]), .busy(busy_o[2]), .tgt_req(treq_o[2]), .tgt_ack(tack[2]),
        .tgt_write(twr_o[2]), .tgt_address(taddr_o[2]), .tgt_wdata(twd_o[2]),
        .tgt_wmask(twm_o[2]), .tgt_rdata(tgt_rdata));

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int lat = 1;
    logic [1:0] spur = 2'b00;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic string nm(string s, int g);
        return $sformatf("%s_u%0d", s, g);
    endfunction

    function automatic int qat(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    // Target responders: ack the requested target once it has been requested for more than lat cycles.
    initial begin
        int cnt[3];
        for (int g = 0; g < 3; g++) begin
            cnt[g] = 0;
            tack[g] = 2'b00;
        end
        forever begin
            @(posedge clk);
            #2;
            for (int g = 0; g < 3; g++) begin
                if (treq_o[g] == 2'b00) begin
                    cnt[g] = 0;
                    tack[g] = spur;
                end else begin
                    cnt[g]++;
                    tack[g] = spur | ((cnt[g] > lat) ? treq_o[g] : 2'b00);
                end
            end
        end
    end

    // Behavioural model: one pending transaction per instance plus arbitration history.
    int   mode_of  [3] = '{0, 1, 1};
    int   limit_of [3] = '{4, 2, 0};
    bit   m_busy   [3];
    int   m_port   [3];
    int   m_tgt    [3];
    int   m_last   [3];
    int   m_gid    [3];
    int   m_streak [3];
    logic          m_write [3];
    logic [AW-1:0] m_addr  [3];
    logic [DW-1:0] m_wdata [3];
    logic [MW-1:0] m_wmask [3];

    task automatic model_reset(int g);
        m_busy[g] = 0; m_port[g] = 0; m_tgt[g] = 0; m_gid[g] = 0;
        m_last[g] = N - 1; m_streak[g] = 0;
        m_write[g] = 0; m_addr[g] = '0; m_wdata[g] = '0; m_wmask[g] = '0;
    endtask

    // Round-robin means the smallest circular distance after the last grant; priority means the smallest index.
    function automatic int pick(int g, logic [N-1:0] r, output bit rr_used);
        int best, bestd, d;
        rr_used = (mode_of[g] == 0) || (limit_of[g] != 0 && m_streak[g] == limit_of[g]);
        best = -1;
        bestd = 2 * N;
        for (int p = 0; p < N; p++) begin
            if (r[p]) begin
                d = rr_used ? (p - m_last[g] - 1 + 2 * N) % N : p;
                if (d < bestd) begin
                    bestd = d;
                    best = p;
                end
            end
        end
        return best;
    endfunction

    task automatic model_step(int g);
        bit rr_used;
        int w;
        if (m_busy[g]) begin
            if (tack[g][m_tgt[g]]) m_busy[g] = 0;
        end else if (req != '0) begin
            w = pick(g, req, rr_used);
            if (mode_of[g] == 1)
                m_streak[g] = rr_used ? 0 : (($countones(req) > 1) ? m_streak[g] + 1 : 0);
            m_busy[g]  = 1;
            m_port[g]  = w;
            m_gid[g]   = w;
            m_last[g]  = w;
            m_addr[g]  = address[w*AW +: AW];
            m_tgt[g]   = int'(m_addr[g][26]);
            m_write[g] = write[w];
            m_wdata[g] = wdata[w*DW +: DW];
            m_wmask[g] = wmask[w*MW +: MW];
        end
    endtask

    task automatic compare(int g);
        logic [N-1:0] e_ack;
        logic [1:0]   e_treq;
        e_treq = m_busy[g] ? ((m_tgt[g] == 1) ? 2'b10 : 2'b01) : 2'b00;
        e_ack  = (m_busy[g] && tack[g][m_tgt[g]]) ? (4'b0001 << m_port[g]) : 4'b0000;
        chk(nm("busy", g),     64'(busy_o[g]),  64'(m_busy[g]));
        chk(nm("grant_id", g), 64'(gid_o[g]),   64'(m_gid[g]));
        chk(nm("tgt_req", g),  64'(treq_o[g]),  64'(e_treq));
        chk(nm("ack", g),      64'(ack_o[g]),   64'(e_ack));
        chk(nm("tgt_write", g), 64'(twr_o[g]),  64'(m_write[g]));
        chk(nm("tgt_addr", g), 64'(taddr_o[g]), 64'(m_addr[g]));
        chk(nm("tgt_wdata", g), 64'(twd_o[g]),  64'(m_wdata[g]));
        chk(nm("tgt_wmask", g), 64'(twm_o[g]),  64'(m_wmask[g]));
        if (e_ack != '0)
            chk(nm("rdata", g), 64'(rdata_o[g]), 64'(tgt_rdata[m_tgt[g]*DW +: DW]));
    endtask

    // Observed grant order per instance. Cycle stamps are kept for the round-robin instance.
    int q_rr[$];
    int q_fp[$];
    int q_fp0[$];
    int qc_rr[$];
    bit pb[3] = '{0, 0, 0};

    // Per-cycle check of every instance against its model, then advance the model.
    always @(negedge clk) begin
        for (int g = 0; g < 3; g++) begin
            if (reset) model_reset(g);
            compare(g);
            if (!reset) model_step(g);
            if (busy_o[g] && !pb[g]) begin
                case (g)
                    0: begin q_rr.push_back(int'(gid_o[0])); qc_rr.push_back(cyc); end
                    1: q_fp.push_back(int'(gid_o[1]));
                    default: q_fp0.push_back(int'(gid_o[2]));
                endcase
            end
            pb[g] = busy_o[g];
        end
    end

    task automatic step(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_q();
        q_rr.delete(); q_fp.delete(); q_fp0.delete(); qc_rr.delete();
    endtask

    task automatic set_port(int p, logic w, logic [AW-1:0] a, logic [DW-1:0] d, logic [MW-1:0] m);
        write[p] = w;
        address[p*AW +: AW] = a;
        wdata[p*DW +: DW] = d;
        wmask[p*MW +: MW] = m;
    endtask

    task automatic wait_ack(int port, output int got);
        got = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (ack_o[0][port]) begin
                got = cyc;
                break;
            end
        end
        chk("ack_seen", 64'(got >= 0), 64'(1));
    endtask

    initial begin
        int s, got, n3;
        @(negedge clk);
        chk("rst_busy", 64'(busy_o[0]), 64'(0));
        chk("rst_treq", 64'(treq_o[0]), 64'(0));
        chk("rst_gid",  64'(gid_o[0]),  64'(0));
        step(1);

        // All four ports continuously; port 3 lives in flash.
        for (int i = 0; i < N; i++)
            set_port(i, logic'(i % 2 == 0), AW'(32'h100 * (i + 1)), DW'(16'h1000 + i), MW'(i));
        set_port(3, 1'b0, 27'h4000300, 16'h1003, 2'b11);
        clear_q();
        lat = 1;
        req = 4'b1111;
        reset = 1'b0;
        step(20);
        chk("rr_order0", 64'(qat(q_rr, 0)), 64'(0));
        chk("rr_order1", 64'(qat(q_rr, 1)), 64'(1));
        chk("rr_order2", 64'(qat(q_rr, 2)), 64'(2));
        chk("rr_order3", 64'(qat(q_rr, 3)), 64'(3));
        chk("rr_order4", 64'(qat(q_rr, 4)), 64'(0));
        chk("rr_spacing", 64'(qat(qc_rr, 1) - qat(qc_rr, 0)), 64'(3));
        chk("fp4_order2", 64'(qat(q_fp, 2)), 64'(1));

        // Ports 0 and 2 continuously: starvation guard at limit 2.
        reset = 1'b1; req = '0;
        step(1);
        clear_q();
        req = 4'b0101;
        reset = 1'b0;
        step(20);
        chk("fp_order0", 64'(qat(q_fp, 0)), 64'(0));
        chk("fp_order1", 64'(qat(q_fp, 1)), 64'(0));
        chk("fp_order2", 64'(qat(q_fp, 2)), 64'(2));
        chk("fp_order3", 64'(qat(q_fp, 3)), 64'(0));
        chk("fp_order4", 64'(qat(q_fp, 4)), 64'(0));
        chk("fp_order5", 64'(qat(q_fp, 5)), 64'(2));
        chk("rr2_order1", 64'(qat(q_rr, 1)), 64'(2));
        chk("fp0_order2", 64'(qat(q_fp0, 2)), 64'(0));

        // Single read from flash by port 1, target answers immediately.
        reset = 1'b1; req = '0;
        step(1);
        reset = 1'b0;
        lat = 0;
        set_port(1, 1'b0, 27'h4000010, 16'h0000, 2'b00);
        req = 4'b0010;
        s = cyc;
        wait_ack(1, got);
        chk("rd_latency", 64'(got - s), 64'(1));
        chk("rd_tgt_req", 64'(treq_o[0]), 64'(2'b10));
        chk("rd_ack", 64'(ack_o[0]), 64'(4'b0010));
        chk("rd_rdata", 64'(rdata_o[0]), 64'(16'hBEEF));
        step(1);
        req = '0;
        step(1);

        // Single write to SDRAM by port 1.
        set_port(1, 1'b1, 27'h0000100, 16'h1234, 2'b01);
        req = 4'b0010;
        wait_ack(1, got);
        chk("wr_tgt_req", 64'(treq_o[0]), 64'(2'b01));
        chk("wr_write", 64'(twr_o[0]), 64'(1));
        chk("wr_addr", 64'(taddr_o[0]), 64'(27'h0000100));
        chk("wr_wdata", 64'(twd_o[0]), 64'(16'h1234));
        chk("wr_wmask", 64'(twm_o[0]), 64'(2'b01));
        step(1);
        req = '0;
        step(1);

        // Slow flash read; the address changes after the grant and a stray SDRAM ack arrives.
        clear_q();
        lat = 5;
        set_port(2, 1'b0, 27'h4000200, 16'h0000, 2'b00);
        req = 4'b0100;
        step(1);
        address[2*AW +: AW] = 27'h0000300;
        spur = 2'b01;
        step(2);
        spur = 2'b00;
        @(negedge clk);
        chk("hold_addr", 64'(taddr_o[0]), 64'(27'h4000200));
        chk("hold_noack", 64'(ack_o[0]), 64'(0));
        wait_ack(2, got);
        chk("slow_delay", 64'(got - qat(qc_rr, 0)), 64'(5));
        chk("slow_rdata", 64'(rdata_o[0]), 64'(16'hBEEF));
        step(1);
        req = '0;
        step(1);

        // Reset in the middle of a transaction, then all ports request.
        req = 4'b0100;
        step(3);
        reset = 1'b1;
        req = 4'b1111;
        @(negedge clk);
        chk("mid_rst_treq", 64'(treq_o[0]), 64'(0));
        chk("mid_rst_ack", 64'(ack_o[0]), 64'(0));
        chk("mid_rst_busy", 64'(busy_o[0]), 64'(0));
        step(1);
        clear_q();
        reset = 1'b0;
        step(4);
        chk("post_rst_first", 64'(qat(q_rr, 0)), 64'(0));

        // Guard disabled: port 3 starves behind port 0, but wins promptly when alone.
        lat = 1;
        reset = 1'b1; req = '0;
        step(1);
        clear_q();
        req = 4'b1001;
        reset = 1'b0;
        step(24);
        n3 = 0;
        foreach (q_fp0[i]) if (q_fp0[i] == 3) n3++;
        chk("fp0_grants", 64'(q_fp0.size() >= 5), 64'(1));
        chk("fp0_port3_never", 64'(n3), 64'(0));
        reset = 1'b1; req = '0;
        step(1);
        req = 4'b1000;
        reset = 1'b0;
        @(negedge clk);
        chk("solo3_idle", 64'(busy_o[2]), 64'(0));
        @(negedge clk);
        chk("solo3_busy", 64'(busy_o[2]), 64'(1));
        chk("solo3_gid", 64'(gid_o[2]), 64'(3));
        step(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
